md_sequencer: RTL and testbench

- Multiply/divide resource for the pipelined MIPS core; sits in the E stage beside the ALU.
- Accepts the decoded md_op/start, hiWE/loWE and mdsel controls, runs a fixed-latency multi-cycle operation, and owns the HI/LO registers.
- Generates the D-stage stall that holds MD-dependent instructions while an operation is in flight or starting.

---
 rtl/md_sequencer_if.sv | 25 ++
 rtl/md_sequencer.sv | 126 ++++++++++++
 tb/tb_md_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// Control/operand bundle between the E-stage decode and the multiply/divide sequencer.
// The master drives the controls and operands; the sequencer returns busy, stall and RD.
interface md_sequencer_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hiWE;
    logic        loWE;
    logic        mdsel;
    logic        D_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] RD;

    modport master (
        output start, md_op, A, B, hiWE, loWE, mdsel, D_md_use,
        input  busy, stall, RD
    );

    modport slave (
        input  start, md_op, A, B, hiWE, loWE, mdsel, D_md_use,
        output busy, stall, RD
    );
endinterface

// File: rtl/md_sequencer.sv
// Fixed-latency multiply/divide unit owning HI/LO for the pipelined MIPS core.
// The result is computed at the start edge and committed when the latency counter expires.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    md_sequencer_if.slave bus
);
    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dz;

    logic        w_start_ok;
    logic        w_is_div;
    logic        w_is_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_den;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_start_ok  = bus.start & ~bus.md_op[2];
    assign w_is_div    = bus.md_op[1];
    assign w_is_signed = ~bus.md_op[0];

    // Operand signs only matter for the signed variants.
    assign w_a_neg = w_is_signed & bus.A[31];
    assign w_b_neg = w_is_signed & bus.B[31];

    // A 64-bit wrap-around product of the extended operands is correct for both signedness cases.
    assign w_a_ext = {{32{w_a_neg}}, bus.A};
    assign w_b_ext = {{32{w_b_neg}}, bus.B};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divide on magnitudes, then restore signs; avoids the signed 0x80000000 / -1 overflow corner.
    assign w_a_mag    = w_a_neg ? (~bus.A + 32'd1) : bus.A;
    assign w_b_mag    = w_b_neg ? (~bus.B + 32'd1) : bus.B;
    assign w_div_zero = (bus.B == 32'd0);
    assign w_b_den    = w_div_zero ? 32'd1 : w_b_mag;
    assign w_uq       = w_a_mag / w_b_den;
    assign w_ur       = w_a_mag % w_b_den;
    assign w_q        = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
    assign w_r        = w_a_neg ? (~w_ur + 32'd1) : w_ur;

    assign w_res_hi = w_is_div ? w_r : w_prod[63:32];
    assign w_res_lo = w_is_div ? w_q : w_prod[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_dz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_dz <= w_is_div & w_div_zero;
                        r_cnt     <= w_is_div ? LP_DIV_CNT : LP_MULT_CNT;
                        r_busy    <= 1'b1;
                        r_state   <= S_BUSY;
                    end else if (!bus.start) begin
                        // Any start, even a reserved op, suppresses mthi/mtlo in the same cycle.
                        if (bus.hiWE) begin
                            r_hi <= bus.A;
                        end
                        if (bus.loWE) begin
                            r_lo <= bus.A;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (!r_pend_dz) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.stall = bus.D_md_use & (r_busy | w_start_ok);
    assign bus.RD    = bus.mdsel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: an arithmetic/timeline model checked every cycle,
// plus literal HI/LO and latency expectations for the listed scenarios.
module tb_md_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_sequencer_if bus();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, got, exp);
        end
    endtask

    // ---------------- model: arithmetic via 64-bit integers, timing via end-edge index
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    bit          m_pdz = 0, m_busy = 0;
    int          m_edge = 0, m_end = 0;

    function automatic logic [64:0] compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] pv;
        sa = 0; sb = 0; q = 0; r = 0; p = 0;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        if (!op[1]) begin
            p  = sa * sb;
            pv = p;
            return {1'b0, pv};
        end
        if (b == 32'd0) return {1'b1, 64'd0};
        q = sa / sb;
        r = sa % sb;
        pv = {r[31:0], q[31:0]};
        return {1'b0, pv};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = 0; m_lo = 0; m_busy = 0; m_edge = 0; m_end = 0;
        end else begin
            m_edge++;
            if (m_busy) begin
                if (m_edge == m_end) begin
                    if (!m_pdz) begin
                        m_hi = m_phi;
                        m_lo = m_plo;
                    end
                    m_busy = 0;
                end
            end else if (bus.start) begin
                if (!bus.md_op[2]) begin
                    {m_pdz, m_phi, m_plo} = compute(bus.md_op, bus.A, bus.B);
                    m_busy = 1;
                    m_end  = m_edge + (bus.md_op[1] ? 10 : 5);
                end
            end else begin
                if (bus.hiWE) m_hi = bus.A;
                if (bus.loWE) m_lo = bus.A;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
            check("stall", {31'd0, bus.stall},
                  {31'd0, bus.D_md_use & (m_busy | (bus.start & ~bus.md_op[2]))});
            check("rd", bus.RD, bus.mdsel ? m_hi : m_lo);
        end
    end

    // ---------------- stimulus helpers
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd, input logic we, output int nb, output int ns);
        bit done;
        done = 0; nb = 0; ns = 0;
        @(posedge clk); #1;
        bus.start = 1; bus.md_op = op; bus.A = a; bus.B = b; bus.D_md_use = dmd; bus.hiWE = we;
        @(negedge clk);
        if (bus.stall) ns++;
        @(posedge clk); #1;
        bus.start = 0; bus.hiWE = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.busy) nb++; else done = 1;
            if (bus.stall) ns++;
        end
        if (!done) check("busy_timeout", {31'd0, bus.busy}, 32'd0);
        #1 bus.D_md_use = 0;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk); #2;
        bus.mdsel = 1; #1 hi = bus.RD;
        bus.mdsel = 0; #1 lo = bus.RD;
    endtask

    task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
        @(posedge clk); #1 bus.hiWE = 1; bus.A = hi;
        @(posedge clk); #1 bus.hiWE = 0; bus.loWE = 1; bus.A = lo;
        @(posedge clk); #1 bus.loWE = 0;
    endtask

    task automatic expect_op(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic dmd, input logic we,
                             input int exp_nb, input int exp_ns,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nb, ns;
        logic [31:0] hi, lo;
        run_op(op, a, b, dmd, we, nb, ns);
        read_hilo(hi, lo);
        check({name, "_busy_cycles"}, nb, exp_nb);
        check({name, "_stall_cycles"}, ns, exp_ns);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        check({name, "_model_hi"}, m_hi, exp_hi);
        check({name, "_model_lo"}, m_lo, exp_lo);
        $display("op %s: op=%03b A=0x%08h B=0x%08h busy_cycles=%0d stall_cycles=%0d HI=0x%08h LO=0x%08h",
                 name, op, a, b, nb, ns, hi, lo);
    endtask

    initial begin
        logic [31:0] hi, lo;
        bus.start = 0; bus.md_op = 0; bus.A = 0; bus.B = 0;
        bus.hiWE = 0; bus.loWE = 0; bus.mdsel = 0; bus.D_md_use = 0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        read_hilo(hi, lo);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        chk_en = 1;

        expect_op("mult",      3'b000, 32'hFFFFFFFD, 32'd5,        1, 0, 5,  6,  32'hFFFFFFFF, 32'hFFFFFFF1);
        expect_op("divu",      3'b011, 32'd7,        32'd2,        0, 0, 10, 0,  32'd1,        32'd3);
        expect_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'd2,        1, 0, 10, 11, 32'hFFFFFFFF, 32'hFFFFFFFD);
        expect_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0, 10, 0,  32'd0,        32'h80000000);
        expect_op("multu",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 5,  0,  32'hFFFFFFFE, 32'd1);

        write_hilo(32'h1234, 32'h5678);
        read_hilo(hi, lo);
        check("preload_hi", hi, 32'h1234);
        check("preload_lo", lo, 32'h5678);
        expect_op("div_zero",  3'b010, 32'd99,       32'd0,        0, 0, 10, 0,  32'h1234,     32'h5678);
        expect_op("reserved",  3'b100, 32'd3,        32'd4,        1, 1, 0,  0,  32'h1234,     32'h5678);
        expect_op("start_we",  3'b000, 32'd3,        32'd4,        1, 1, 5,  6,  32'd0,        32'd12);

        // Reset in the third busy cycle of a divide
        @(posedge clk); #1;
        bus.start = 1; bus.md_op = 3'b010; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk); #1 bus.start = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_lo", bus.RD, 32'd0);
        @(posedge clk); #1 rst_n = 1;
        repeat (15) @(posedge clk);
        read_hilo(hi, lo);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);
        check("rst_after_busy", {31'd0, bus.busy}, 32'd0);
        $display("op reset_mid_div: HI=0x%08h LO=0x%08h busy=%0d", hi, lo, bus.busy);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
